// File: rtl/priority_irq_encoder.sv
// Registered N-to-log2(N) priority encoder: sticky request capture, per-line
// masking, fixed (MSB wins) or descending round-robin selection, valid/ack grant.
module priority_irq_encoder #(
   parameter int  N    = 16,
   parameter int  EDGE = 1,
   parameter int  RR   = 0,
   localparam int W    = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic [N-1:0] mask,
   input  logic         ack,
   output logic [W-1:0] out_idx,
   output logic         valid,
   output logic [N-1:0] pending
);

   typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

   function automatic logic [W-1:0] highest_idx(input logic [N-1:0] v);
      logic [W-1:0] idx;
      idx = {W{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            idx = W'(i);
         end
      end
      return idx;
   endfunction

   state_t       state_q, state_d;
   logic [N-1:0] req_q, req_d;
   logic [N-1:0] pending_q, pending_d;
   logic [W-1:0] out_idx_q, out_idx_d;
   logic         valid_q, valid_d;
   logic [W-1:0] last_q, last_d;

   logic [N-1:0] set_s;
   logic [N-1:0] clr_s;
   logic [N-1:0] elig_s;
   logic [N-1:0] below_s;
   logic [N-1:0] elig_lo_s;
   logic [W-1:0] winner_s;
   logic         take_s;

   // Capture, clear and eligibility; a set in the same cycle beats the clear.
   always_comb begin
      take_s = valid_q & ack;
      req_d  = req;
      clr_s  = {N{1'b0}};
      if (take_s) begin
         clr_s[out_idx_q] = 1'b1;
      end else begin
         clr_s = {N{1'b0}};
      end
      if (EDGE != 0) begin
         set_s = req & ~req_q;
      end else begin
         set_s = req;
      end
      pending_d = (pending_q & ~clr_s) | set_s;
      elig_s    = pending_q & mask & ~clr_s;
   end

   // Winner select; round-robin looks strictly below last, then wraps to the top.
   always_comb begin
      below_s = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         below_s[i] = (W'(i) < last_q);
      end
      elig_lo_s = elig_s & below_s;
      if ((RR != 0) && (elig_lo_s != {N{1'b0}})) begin
         winner_s = highest_idx(elig_lo_s);
      end else begin
         winner_s = highest_idx(elig_s);
      end
   end

   // Grant FSM: a grant is only replaced on ack, never revoked.
   always_comb begin
      state_d   = state_q;
      out_idx_d = out_idx_q;
      valid_d   = valid_q;
      last_d    = last_q;
      if (take_s) begin
         last_d = out_idx_q;
      end else begin
         last_d = last_q;
      end
      case (state_q)
         IDLE: begin
            if (elig_s != {N{1'b0}}) begin
               out_idx_d = winner_s;
               valid_d   = 1'b1;
               state_d   = GRANT;
            end else begin
               valid_d = 1'b0;
            end
         end
         GRANT: begin
            if (ack) begin
               if (elig_s != {N{1'b0}}) begin
                  out_idx_d = winner_s;
                  valid_d   = 1'b1;
               end else begin
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end else begin
               valid_d = 1'b1;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         req_q     <= {N{1'b0}};
         pending_q <= {N{1'b0}};
         out_idx_q <= {W{1'b0}};
         valid_q   <= 1'b0;
         last_q    <= {W{1'b0}};
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         pending_q <= pending_d;
         out_idx_q <= out_idx_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
      end
   end

   assign out_idx = out_idx_q;
   assign valid   = valid_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_priority_irq_encoder.sv
// Scoreboard bench: expectations are queued with a target cycle as stimulus is
// driven, and compared on the falling edge of that cycle.
module tb_priority_irq_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] req_a = 16'h0000, mask_a = 16'hFFFF;
   logic        ack_a = 1'b0;
   logic [3:0]  out_a;
   logic        valid_a;
   logic [15:0] pend_a;
   logic [15:0] req_b = 16'h0000, mask_b = 16'hFFFF;
   logic        ack_b = 1'b0;
   logic [3:0]  out_b;
   logic        valid_b;
   logic [15:0] pend_b;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int          cyc;
      string       tag;
      int          sel;
      logic [15:0] val;
   } exp_t;
   exp_t sb_q[$];

   localparam int S_VA = 0, S_IA = 1, S_PA = 2, S_VB = 3, S_IB = 4, S_PB = 5;

   priority_irq_encoder #(.N(16), .EDGE(1), .RR(0)) u_dut (
      .clk(clk), .rst(rst), .req(req_a), .mask(mask_a), .ack(ack_a),
      .out_idx(out_a), .valid(valid_a), .pending(pend_a)
   );

   priority_irq_encoder #(.N(16), .EDGE(0), .RR(1)) u_dut_rr (
      .clk(clk), .rst(rst), .req(req_b), .mask(mask_b), .ack(ack_b),
      .out_idx(out_b), .valid(valid_b), .pending(pend_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] pick(input int sel);
      case (sel)
         S_VA:    return 16'(valid_a);
         S_IA:    return 16'(out_a);
         S_PA:    return pend_a;
         S_VB:    return 16'(valid_b);
         S_IB:    return 16'(out_b);
         S_PB:    return pend_b;
         default: return 16'hDEAD;
      endcase
   endfunction

   task automatic expect_at(input string tag, input int off, input int sel, input logic [15:0] val);
      exp_t e;
      e.cyc = cyc + off;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].cyc == cyc) begin
            check(sb_q[i].tag, pick(sb_q[i].sel), sb_q[i].val);
            sb_q.delete(i);
         end
      end
   end

   initial begin
      #1;
      check("rst_valid", 16'(valid_a), 16'h0000);
      check("rst_idx", 16'(out_a), 16'h0000);
      check("rst_pend", pend_a, 16'h0000);
      step(2);
      rst = 1'b0;
      step(1);

      // 1: single pulse, grant and release
      req_a = 16'h0001;
      expect_at("t1_pend", 1, S_PA, 16'h0001);
      expect_at("t1_valid", 2, S_VA, 16'h0001);
      expect_at("t1_idx", 2, S_IA, 16'h0000);
      expect_at("t1_pend_held", 2, S_PA, 16'h0001);
      step(1);
      req_a = 16'h0000;
      step(1);
      ack_a = 1'b1;
      expect_at("t1_valid_off", 1, S_VA, 16'h0000);
      expect_at("t1_pend_clr", 1, S_PA, 16'h0000);
      step(1);
      ack_a = 1'b0;
      step(2);

      // 2: two lines, MSB first, then next on ack
      req_a = 16'h8100;
      expect_at("t2_valid", 2, S_VA, 16'h0001);
      expect_at("t2_idx15", 2, S_IA, 16'h000F);
      step(1);
      req_a = 16'h0000;
      step(1);
      ack_a = 1'b1;
      expect_at("t2_idx8", 1, S_IA, 16'h0008);
      expect_at("t2_valid_kept", 1, S_VA, 16'h0001);
      expect_at("t2_pend", 1, S_PA, 16'h0100);
      step(1);
      expect_at("t2_valid_off", 1, S_VA, 16'h0000);
      expect_at("t2_pend_clr", 1, S_PA, 16'h0000);
      step(1);
      ack_a = 1'b0;
      step(2);

      // 3: outstanding grant is not preempted
      req_a = 16'h0008;
      expect_at("t3_idx3", 2, S_IA, 16'h0003);
      step(1);
      req_a = 16'h0000;
      step(1);
      req_a = 16'h1000;
      for (int k = 1; k <= 10; k++) begin
         expect_at("t3_hold_idx", k, S_IA, 16'h0003);
         expect_at("t3_hold_valid", k, S_VA, 16'h0001);
      end
      expect_at("t3_pend", 5, S_PA, 16'h1008);
      step(1);
      req_a = 16'h0000;
      step(9);
      ack_a = 1'b1;
      expect_at("t3_idx12", 1, S_IA, 16'h000C);
      expect_at("t3_valid", 1, S_VA, 16'h0001);
      step(1);
      expect_at("t3_valid_off", 1, S_VA, 16'h0000);
      step(1);
      ack_a = 1'b0;
      step(2);

      // 4: masked line stays pending until unmasked
      mask_a = 16'hFFDF;
      req_a  = 16'h0020;
      expect_at("t4_pend", 1, S_PA, 16'h0020);
      expect_at("t4_masked_v", 2, S_VA, 16'h0000);
      expect_at("t4_masked_v2", 3, S_VA, 16'h0000);
      expect_at("t4_pend_kept", 3, S_PA, 16'h0020);
      step(1);
      req_a = 16'h0000;
      step(2);
      mask_a = 16'hFFFF;
      expect_at("t4_valid", 1, S_VA, 16'h0001);
      expect_at("t4_idx5", 1, S_IA, 16'h0005);
      step(1);
      ack_a = 1'b1;
      expect_at("t4_valid_off", 1, S_VA, 16'h0000);
      step(1);
      ack_a = 1'b0;
      step(2);

      // 5: round-robin, level mode, all lines held, ack every cycle
      req_b = 16'hFFFF;
      ack_b = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         expect_at("t5_rr_idx", 2 + k, S_IB, 16'((15 - k) & 15));
         expect_at("t5_rr_valid", 2 + k, S_VB, 16'h0001);
      end
      expect_at("t5_repend", 16, S_PB, 16'hFFFF);
      step(18);
      req_b = 16'h0000;
      step(20);
      expect_at("t5_drain_v", 1, S_VB, 16'h0000);
      expect_at("t5_drain_p", 1, S_PB, 16'h0000);
      step(2);
      ack_b = 1'b0;
      step(2);

      // 6: async reset mid-grant, req held through reset
      req_a = 16'h0010;
      step(1);
      req_a = 16'h0000;
      step(1);
      check("t6_pre_idx", 16'(out_a), 16'h0004);
      req_a = 16'h0080;
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_valid", 16'(valid_a), 16'h0000);
      check("t6_rst_idx", 16'(out_a), 16'h0000);
      check("t6_rst_pend", pend_a, 16'h0000);
      step(2);
      rst = 1'b0;
      expect_at("t6_pend7", 1, S_PA, 16'h0080);
      expect_at("t6_valid", 2, S_VA, 16'h0001);
      expect_at("t6_idx7", 2, S_IA, 16'h0007);
      step(3);
      ack_a = 1'b1;
      expect_at("t6_valid_off", 1, S_VA, 16'h0000);
      step(1);
      ack_a = 1'b0;
      req_a = 16'h0000;
      step(3);

      check("sb_drain", 16'(sb_q.size()), 16'h0000);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
